optical_tx_scheduler: RTL

//  Shares the single optical OOK serializer (start bit + 8 data bits + stop) among
//  NUM_REQ byte sources, e.g. UART RX bytes, link beacons and ACK generation.

---
 rtl/optical_tx_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/optical_tx_scheduler.sv
// Round-robin scheduler sharing one OOK byte serializer among NUM_REQ sources,
// with a post-frame guard gap and a watchdog on frame completion.
module optical_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int GUARD_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 ser_start_o,
  output logic [7:0]           ser_data_o,
  input  logic                 ser_busy_i,
  input  logic                 ser_done_i,
  output logic [2:0]           grant_id_o,
  output logic                 link_idle_o,
  output logic                 timeout_err_o
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(NUM_REQ);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GD_LAST = CW'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GUARD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CW-1:0] guard_cnt_q, guard_cnt_d;
  logic [7:0]    ser_data_q, ser_data_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic          ser_start_q, ser_start_d;
  logic          timeout_err_q, timeout_err_d;

  logic          found_s;
  logic          accept_s;
  logic          expire_s;
  logic [2:0]    winner_s;
  logic [3:0]    scan_s;
  logic [7:0]    win_data_s;

  // Round-robin search starting at rr_ptr, plus the winner's byte.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = 3'd0;
    scan_s     = 4'd0;
    win_data_s = 8'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_s = 4'(rr_ptr_q) + 4'(k);
      if (scan_s >= 4'(NUM_REQ)) begin
        scan_s = scan_s - 4'(NUM_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && req_valid_i[IW'(scan_s)]) begin
        found_s  = 1'b1;
        winner_s = 3'(scan_s);
      end else begin
        found_s  = found_s;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == winner_s) begin
        win_data_s = req_data_i[8*i +: 8];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  assign accept_s = (state_q == S_IDLE) && found_s && !ser_busy_i;
  assign expire_s = (state_q == S_WAIT) && !ser_done_i && (wait_cnt_q == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done pulse takes precedence over watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_ISSUE;
        else          state_d = S_IDLE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (ser_done_i || expire_s) state_d = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
        else                        state_d = S_WAIT;
      end
      S_GUARD: begin
        if (guard_cnt_q == GD_LAST) state_d = S_IDLE;
        else                        state_d = S_GUARD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM-decoded outputs: one-hot accept and idle indication.
  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = accept_s && (3'(i) == winner_s);
    end
    link_idle_o = (state_q == S_IDLE);
  end

  // Datapath next values: byte latch, pointer rotation, counters, pulses.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    ser_data_d    = ser_data_q;
    grant_id_d    = grant_id_q;
    wait_cnt_d    = wait_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    ser_start_d   = accept_s;
    timeout_err_d = expire_s;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          ser_data_d = win_data_s;
          grant_id_d = winner_s;
          rr_ptr_d   = (winner_s == 3'(NUM_REQ - 1)) ? 3'd0 : (winner_s + 3'd1);
        end else begin
          rr_ptr_d   = rr_ptr_q;
        end
      end
      S_ISSUE: wait_cnt_d = '0;
      S_WAIT: begin
        guard_cnt_d = '0;
        if (wait_cnt_q != TO_LAST) wait_cnt_d = wait_cnt_q + 1'b1;
        else                       wait_cnt_d = wait_cnt_q;
      end
      S_GUARD: begin
        if (guard_cnt_q != GD_LAST) guard_cnt_d = guard_cnt_q + 1'b1;
        else                        guard_cnt_d = guard_cnt_q;
      end
      default: begin
        wait_cnt_d  = '0;
        guard_cnt_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= 3'd0;
      ser_data_q    <= 8'd0;
      grant_id_q    <= 3'd0;
      wait_cnt_q    <= '0;
      guard_cnt_q   <= '0;
      ser_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      ser_data_q    <= ser_data_d;
      grant_id_q    <= grant_id_d;
      wait_cnt_q    <= wait_cnt_d;
      guard_cnt_q   <= guard_cnt_d;
      ser_start_q   <= ser_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ser_start_o   = ser_start_q;
  assign ser_data_o    = ser_data_q;
  assign grant_id_o    = grant_id_q;
  assign timeout_err_o = timeout_err_q;

endmodule
